// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the regfile writeback arbiter: requester indices,
// default sizes and the per-source request record.
package regfile_wb_arbiter_pkg;

    localparam int WB_ALU     = 0;
    localparam int WB_LSU     = 1;
    localparam int WB_MDU     = 2;

    localparam int WB_NREQ    = 3;
    localparam int WB_XLEN    = 32;
    localparam int WB_REGNO_W = 6;

    typedef struct packed {
        logic                  valid;
        logic [WB_REGNO_W-1:0] rd_no;
        logic [WB_XLEN-1:0]    dat;
    } wb_req_t;

    function automatic logic is_x0(input logic [WB_REGNO_W-1:0] rd_no);
        return (rd_no == {WB_REGNO_W{1'b0}});
    endfunction

endpackage

// File: rtl/wb_age_prio_pick.sv
// Combinational winner pick: the lowest-index saturated request wins if any,
// otherwise the lowest-index real request. i_sat is expected to be a subset of i_real.
module wb_age_prio_pick
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_real,
    input  logic [NREQ-1:0] i_sat,
    output logic [NREQ-1:0] o_grant_oh,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_grant_any
);

    logic [NREQ-1:0] w_mask;
    logic            w_taken;

    // Priority scan over the active mask; first set bit is the one-hot winner.
    always_comb begin
        w_mask      = (|i_sat) ? i_sat : i_real;
        o_grant_oh  = {NREQ{1'b0}};
        o_grant_idx = {IW{1'b0}};
        w_taken     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            o_grant_oh[k] = w_mask[k] & ~w_taken;
            w_taken       = w_taken | w_mask[k];
            o_grant_idx   = o_grant_idx | (o_grant_oh[k] ? IW'(k) : {IW{1'b0}});
        end
        o_grant_any = |w_mask;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile's single write port among writeback sources,
// absorbing x0 writes and aging waiting requests so none starves.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ     = WB_NREQ,
    parameter int XLEN     = WB_XLEN,
    parameter int REGNO_W  = WB_REGNO_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_hold,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*REGNO_W-1:0]   i_req_rd_no,
    input  logic [NREQ*XLEN-1:0]      i_req_dat,
    output logic [NREQ-1:0]           o_req_ready,
    output logic                      o_write,
    output logic [REGNO_W-1:0]        o_rd_no,
    output logic [XLEN-1:0]           o_rd_dat,
    output logic [$clog2(NREQ)-1:0]   o_grant_idx
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

    wb_req_t             w_req [NREQ];
    logic [NREQ-1:0]     w_x0;
    logic [NREQ-1:0]     w_real;
    logic [NREQ-1:0]     w_cand;
    logic [NREQ-1:0]     w_sat;
    logic [NREQ-1:0]     w_grant_oh;
    logic [IW-1:0]       w_grant_idx;
    logic                w_grant_any;
    logic [REGNO_W-1:0]  w_win_rd;
    logic [XLEN-1:0]     w_win_dat;

    logic [CW-1:0]       r_wait [NREQ];
    logic                r_write;
    logic [REGNO_W-1:0]  r_rd_no;
    logic [XLEN-1:0]     r_rd_dat;
    logic [IW-1:0]       r_grant_idx;

    // Unpack the request buses and classify each request as x0, real or candidate.
    always_comb begin
        w_x0   = {NREQ{1'b0}};
        w_real = {NREQ{1'b0}};
        w_cand = {NREQ{1'b0}};
        w_sat  = {NREQ{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_req[k].valid = i_req_valid[k];
            w_req[k].rd_no = WB_REGNO_W'(i_req_rd_no[k*REGNO_W +: REGNO_W]);
            w_req[k].dat   = WB_XLEN'(i_req_dat[k*XLEN +: XLEN]);
            w_x0[k]        = w_req[k].valid &  is_x0(w_req[k].rd_no);
            w_real[k]      = w_req[k].valid & ~is_x0(w_req[k].rd_no);
            // Hold only blocks port grants; x0 absorption is unaffected.
            w_cand[k]      = w_real[k] & ~i_hold;
            w_sat[k]       = w_cand[k] & (r_wait[k] == WAIT_SAT);
        end
    end

    wb_age_prio_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_real      (w_cand),
        .i_sat       (w_sat),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    assign o_req_ready = w_x0 | w_grant_oh;

    // One-hot mux of the winner's register number and data.
    always_comb begin
        w_win_rd  = {REGNO_W{1'b0}};
        w_win_dat = {XLEN{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_win_rd  = w_win_rd  | (w_grant_oh[k] ? REGNO_W'(w_req[k].rd_no) : {REGNO_W{1'b0}});
            w_win_dat = w_win_dat | (w_grant_oh[k] ? XLEN'(w_req[k].dat)      : {XLEN{1'b0}});
        end
    end

    // Per-requester wait counters; they keep counting while hold is asserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                r_wait[k] <= {CW{1'b0}};
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (w_grant_oh[k] || !w_real[k]) begin
                    r_wait[k] <= {CW{1'b0}};
                end else if (r_wait[k] != WAIT_SAT) begin
                    r_wait[k] <= r_wait[k] + CW'(1);
                end else begin
                    r_wait[k] <= r_wait[k];
                end
            end
        end
    end

    // Registered write port; payload holds its last value when no write occurs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write     <= 1'b0;
            r_rd_no     <= {REGNO_W{1'b0}};
            r_rd_dat    <= {XLEN{1'b0}};
            r_grant_idx <= {IW{1'b0}};
        end else begin
            r_write <= w_grant_any;
            if (w_grant_any) begin
                r_rd_no     <= w_win_rd;
                r_rd_dat    <= w_win_dat;
                r_grant_idx <= w_grant_idx;
            end else begin
                r_rd_no     <= r_rd_no;
                r_rd_dat    <= r_rd_dat;
                r_grant_idx <= r_grant_idx;
            end
        end
    end

    assign o_write     = r_write;
    assign o_rd_no     = r_rd_no;
    assign o_rd_dat    = r_rd_dat;
    assign o_grant_idx = r_grant_idx;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed cycles push expected writes,
// an independent monitor pops and compares whenever the write port fires.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [5:0]  rd;
        logic [31:0] dat;
        logic [1:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic [2:0]  valid;
    logic [17:0] rd_bus;
    logic [95:0] dat_bus;
    logic [2:0]  ready;
    logic        o_write;
    logic [5:0]  o_rd_no;
    logic [31:0] o_rd_dat;
    logic [1:0]  o_grant_idx;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    regfile_wb_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hold      (hold),
        .i_req_valid (valid),
        .i_req_rd_no (rd_bus),
        .i_req_dat   (dat_bus),
        .o_req_ready (ready),
        .o_write     (o_write),
        .o_rd_no     (o_rd_no),
        .o_rd_dat    (o_rd_dat),
        .o_grant_idx (o_grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: apply inputs, check ready mid-cycle, queue the expected write.
    task automatic drive(input logic h, input logic [2:0] v,
                         input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [2:0] exp_rdy, input logic exp_w,
                         input logic [5:0] erd, input logic [31:0] edat, input logic [1:0] eidx);
        exp_t e;
        hold    = h;
        valid   = v;
        rd_bus  = {r2, r1, r0};
        dat_bus = {d2, d1, d0};
        @(negedge clk);
        chk("ready", {29'd0, ready}, {29'd0, exp_rdy});
        if (exp_w) begin
            e.rd  = erd;
            e.dat = edat;
            e.idx = eidx;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0,
              3'b000, 1'b0, 6'd0, 32'd0, 2'd0);
    endtask

    // Monitor: every write-port pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_write === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {26'd0, o_rd_no}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_rd_no", {26'd0, o_rd_no}, {26'd0, e.rd});
                chk("wr_dat", o_rd_dat, e.dat);
                chk("wr_idx", {30'd0, o_grant_idx}, {30'd0, e.idx});
            end
            chk("wr_not_x0", {31'd0, (o_rd_no != 6'd0)}, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with every source requesting.
        rst_n   = 1'b0;
        hold    = 1'b0;
        valid   = 3'b111;
        rd_bus  = {6'd3, 6'd2, 6'd1};
        dat_bus = {32'h33, 32'h22, 32'h11};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", {31'd0, o_write}, 32'd0);
        chk("rst_rd_no", {26'd0, o_rd_no}, 32'd0);
        chk("rst_dat", o_rd_dat, 32'd0);
        chk("rst_idx", {30'd0, o_grant_idx}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 3'b001, 6'd5, 6'd0, 6'd0, 32'hDEADBEEF, 32'd0, 32'd0,
              3'b001, 1'b1, 6'd5, 32'hDEADBEEF, 2'd0);
        idle();

        // Three distinct destinations drain in index order, back to back.
        drive(1'b0, 3'b111, 6'd3, 6'd7, 6'd9, 32'hA3, 32'hA7, 32'hA9,
              3'b001, 1'b1, 6'd3, 32'hA3, 2'd0);
        drive(1'b0, 3'b110, 6'd3, 6'd7, 6'd9, 32'hA3, 32'hA7, 32'hA9,
              3'b010, 1'b1, 6'd7, 32'hA7, 2'd1);
        drive(1'b0, 3'b100, 6'd3, 6'd7, 6'd9, 32'hA3, 32'hA7, 32'hA9,
              3'b100, 1'b1, 6'd9, 32'hA9, 2'd2);
        idle();
        idle();

        // req0 streams; req2 ages to saturation and wins on its fifth cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'b101, 6'(20 + i), 6'd0, 6'd12, 32'(32'h100 + i), 32'd0, 32'hC12,
                  3'b001, 1'b1, 6'(20 + i), 32'(32'h100 + i), 2'd0);
        end
        drive(1'b0, 3'b101, 6'd24, 6'd0, 6'd12, 32'h104, 32'd0, 32'hC12,
              3'b100, 1'b1, 6'd12, 32'hC12, 2'd2);
        drive(1'b0, 3'b001, 6'd24, 6'd0, 6'd0, 32'h104, 32'd0, 32'd0,
              3'b001, 1'b1, 6'd24, 32'h104, 2'd0);
        idle();

        // x0 absorbed alongside a real write in the same cycle.
        drive(1'b0, 3'b011, 6'd4, 6'd0, 6'd0, 32'h44, 32'h99, 32'd0,
              3'b011, 1'b1, 6'd4, 32'h44, 2'd0);
        idle();

        // Hold for 6 cycles: req1 saturates, x0 still absorbed; req1 wins on release.
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                drive(1'b1, 3'b110, 6'd0, 6'd8, 6'd0, 32'd0, 32'h88, 32'h77,
                      3'b100, 1'b0, 6'd0, 32'd0, 2'd0);
            end else begin
                drive(1'b1, 3'b010, 6'd0, 6'd8, 6'd0, 32'd0, 32'h88, 32'd0,
                      3'b000, 1'b0, 6'd0, 32'd0, 2'd0);
            end
        end
        drive(1'b0, 3'b011, 6'd10, 6'd8, 6'd0, 32'h1A, 32'h88, 32'd0,
              3'b010, 1'b1, 6'd8, 32'h88, 2'd1);
        drive(1'b0, 3'b001, 6'd10, 6'd8, 6'd0, 32'h1A, 32'h88, 32'd0,
              3'b001, 1'b1, 6'd10, 32'h1A, 2'd0);
        idle();

        // Shorter hold: counter not yet saturated, so base priority applies.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b010, 6'd0, 6'd8, 6'd0, 32'd0, 32'hB8, 32'd0,
                  3'b000, 1'b0, 6'd0, 32'd0, 2'd0);
        end
        drive(1'b0, 3'b011, 6'd13, 6'd8, 6'd0, 32'hD13, 32'hB8, 32'd0,
              3'b001, 1'b1, 6'd13, 32'hD13, 2'd0);
        drive(1'b0, 3'b010, 6'd13, 6'd8, 6'd0, 32'hD13, 32'hB8, 32'd0,
              3'b010, 1'b1, 6'd8, 32'hB8, 2'd1);
        idle();
        idle();

        // Asynchronous reset while a write is on the port.
        drive(1'b0, 3'b001, 6'd6, 6'd0, 6'd0, 32'h66, 32'd0, 32'd0,
              3'b001, 1'b1, 6'd6, 32'h66, 2'd0);
        chk("pre_rst_write", {31'd0, o_write}, 32'd1);
        valid = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_write", {31'd0, o_write}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        idle();
        drive(1'b0, 3'b100, 6'd0, 6'd0, 6'd11, 32'd0, 32'd0, 32'hE11,
              3'b100, 1'b1, 6'd11, 32'hE11, 2'd2);
        idle();

        // Bounded drain of any outstanding expected writes.
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
